// File: rtl/adder4_result_accum.sv
// rtl/adder4_result_accum.sv - accumulates N adder results per frame and hands off the frame total
module adder4_result_accum #(
    parameter int ACC_W = 12,
    parameter int N     = 8
) (
    input  logic             clk1,
    input  logic             rst1,
    input  logic [3:0]       Sum,
    input  logic             C,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [7:0]       cnt,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(N - 1);
    localparam logic [7:0] CNT_FULL = 8'(N);

    state_t           state;
    logic [ACC_W:0]   sum_ext;

    // One extra bit catches the carry out of the accumulator for the sticky flag.
    assign sum_ext  = {1'b0, acc_out} + (ACC_W + 1)'({C, Sum});
    assign in_ready = (state == ACCUM) && !rst1;

    always_ff @(posedge clk1) begin
        if (rst1 || clear) begin
            state     <= ACCUM;
            acc_out   <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc_out <= sum_ext[ACC_W-1:0];
                        if (sum_ext[ACC_W])
                            ovf <= 1'b1;
                        if (cnt == CNT_LAST) begin
                            cnt       <= CNT_FULL;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    // No bypass: the next frame starts accepting one cycle after handoff.
                    if (out_ready) begin
                        state     <= ACCUM;
                        acc_out   <= '0;
                        ovf       <= 1'b0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_adder4_result_accum.sv
// tb/tb_adder4_result_accum.sv - checks two accumulator configurations against a frame-sum model
`timescale 1ns/1ps
module tb_adder4_result_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [2];
    logic       clr_v   [2];
    logic       vld_v   [2];
    logic       ordy_v  [2];
    logic [4:0] val_v   [2];

    logic [11:0] acc_a;
    logic [4:0]  acc_b;
    logic        ovf_a, ovf_b, ov_a, ov_b, ir_a, ir_b;
    logic [7:0]  cnt_a, cnt_b;

    adder4_result_accum #(.ACC_W(12), .N(4)) dut_a (
        .clk1(clk), .rst1(rst_v[0]), .Sum(val_v[0][3:0]), .C(val_v[0][4]),
        .in_valid(vld_v[0]), .in_ready(ir_a), .clear(clr_v[0]), .acc_out(acc_a),
        .ovf(ovf_a), .cnt(cnt_a), .out_valid(ov_a), .out_ready(ordy_v[0])
    );

    adder4_result_accum #(.ACC_W(5), .N(2)) dut_b (
        .clk1(clk), .rst1(rst_v[1]), .Sum(val_v[1][3:0]), .C(val_v[1][4]),
        .in_valid(vld_v[1]), .in_ready(ir_b), .clear(clr_v[1]), .acc_out(acc_b),
        .ovf(ovf_b), .cnt(cnt_b), .out_valid(ov_b), .out_ready(ordy_v[1])
    );

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    // Model: exact frame sum as an unbounded integer plus count of results taken.
    longint m_total [2];
    int     m_count [2];

    function automatic int n_of(int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int w_of(int i);
        return (i == 0) ? 12 : 5;
    endfunction

    function automatic bit m_done(int i);
        return m_count[i] == n_of(i);
    endfunction

    task automatic check(string name, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_v[i] || clr_v[i]) begin
                m_total[i] = 0;
                m_count[i] = 0;
            end else if (m_done(i)) begin
                if (ordy_v[i]) begin
                    m_total[i] = 0;
                    m_count[i] = 0;
                end
            end else if (vld_v[i]) begin
                m_total[i] += val_v[i];
                m_count[i]++;
            end
        end
        if (rst_v[0] && rst_v[1])
            armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                longint lim;
                lim = longint'(1) << w_of(i);
                check($sformatf("acc[%0d]", i), (i == 0) ? longint'(acc_a) : longint'(acc_b), m_total[i] % lim);
                check($sformatf("ovf[%0d]", i), (i == 0) ? ovf_a : ovf_b, m_total[i] >= lim);
                check($sformatf("cnt[%0d]", i), (i == 0) ? cnt_a : cnt_b, m_count[i]);
                check($sformatf("out_valid[%0d]", i), (i == 0) ? ov_a : ov_b, m_done(i));
                check($sformatf("in_ready[%0d]", i), (i == 0) ? ir_a : ir_b, !m_done(i) && !rst_v[i]);
            end
        end
    end

    task automatic set_in(int i, bit v, logic [4:0] d, bit o, bit c, bit r);
        vld_v[i]  = v;
        val_v[i]  = d;
        ordy_v[i] = o;
        clr_v[i]  = c;
        rst_v[i]  = r;
    endtask

    task automatic drive(int i, bit v, logic [4:0] d, bit o = 1'b0, bit c = 1'b0, bit r = 1'b0);
        set_in(i, v, d, o, c, r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_total[i] = 0;
            m_count[i] = 0;
            set_in(i, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_in_ready_a", ir_a, 0);
        check("reset_acc_a", acc_a, 0);
        check("reset_out_valid_b", ov_b, 0);
        set_in(0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("first_in_ready_a", ir_a, 1);

        // basic frame, N=4
        drive(0, 1, 5'd5);
        drive(0, 1, 5'd10);
        drive(0, 1, 5'd31);
        drive(0, 1, 5'd1, 1);
        check("basic_valid", ov_a, 1);
        check("basic_acc", acc_a, 47);
        check("basic_ovf", ovf_a, 0);
        check("basic_cnt", cnt_a, 4);
        drive(0, 0, 5'd0, 1);
        check("basic_after_acc", acc_a, 0);
        check("basic_after_ready", ir_a, 1);

        // input gaps
        drive(0, 1, 5'd4, 0);
        check("gap_cnt1", cnt_a, 1);
        drive(0, 0, 5'd0);
        drive(0, 0, 5'd0);
        check("gap_hold", cnt_a, 1);
        drive(0, 1, 5'd6);
        check("gap_cnt2", cnt_a, 2);
        drive(0, 0, 5'd0);
        drive(0, 1, 5'd7);
        check("gap_cnt3", cnt_a, 3);
        check("gap_acc", acc_a, 17);
        drive(0, 1, 5'd3);
        drive(0, 0, 5'd0, 1);

        // clear mid-frame and in DONE
        drive(0, 1, 5'd8);
        drive(0, 1, 5'd9);
        drive(0, 1, 5'd2, 0, 1);
        check("clear_acc", acc_a, 0);
        check("clear_cnt", cnt_a, 0);
        repeat (4) drive(0, 1, 5'd1);
        check("fill_valid", ov_a, 1);
        drive(0, 0, 5'd0, 0, 1);
        check("clear_done_valid", ov_a, 0);
        check("clear_done_acc", acc_a, 0);

        // reset mid-frame and in DONE
        drive(0, 1, 5'd3);
        drive(0, 1, 5'd3);
        drive(0, 1, 5'd3, 0, 0, 1);
        check("rst_mid_cnt", cnt_a, 0);
        check("rst_mid_ready", ir_a, 0);
        repeat (4) drive(0, 1, 5'd2);
        drive(0, 1, 5'd2, 1, 0, 1);
        check("rst_done_valid", ov_a, 0);
        check("rst_done_acc", acc_a, 0);
        drive(0, 0, 5'd0);

        // overflow wrap, N=2 ACC_W=5
        drive(1, 1, 5'd31);
        drive(1, 1, 5'd1);
        check("wrap_acc", acc_b, 0);
        check("wrap_ovf", ovf_b, 1);
        check("wrap_valid", ov_b, 1);
        drive(1, 0, 5'd0, 1);
        check("wrap_ovf_cleared", ovf_b, 0);
        drive(1, 1, 5'd3);
        drive(1, 1, 5'd4);
        check("next_acc", acc_b, 7);
        check("next_ovf", ovf_b, 0);
        drive(1, 0, 5'd0, 1);

        // backpressure
        drive(1, 1, 5'd2);
        drive(1, 1, 5'd3);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 5'd9, 0);
            check("bp_acc", acc_b, 5);
            check("bp_ready", ir_b, 0);
        end
        drive(1, 1, 5'd9, 1);
        check("bp_release_acc", acc_b, 0);
        drive(1, 1, 5'd9, 0);
        check("bp_next_acc", acc_b, 9);
        check("bp_next_cnt", cnt_b, 1);

        // randomized traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++)
                set_in(i, $urandom_range(0, 9) < 7, 5'($urandom), $urandom_range(0, 1),
                       $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
